// File: rtl/midi_parser.sv
// MIDI byte-stream parser: turns UART bytes into complete channel, system-common
// and real-time messages, with running status, sysex framing and a one-deep
// output holding register with valid/ack handshake.
module midi_parser #(
    parameter bit RT_PASS = 1'b1,
    parameter bit DROP_FE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_data_rdy,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic [1:0] msg_len,
    output logic       msg_valid,
    input  logic       msg_ack,
    output logic       sysex_active,
    output logic       overflow,
    output logic       orphan
);

    typedef enum logic [1:0] {StIdle, StWaitD1, StWaitD2, StSysex} state_e;

    state_e     state_q, state_d;
    logic [7:0] rs_q, rs_d;
    logic [6:0] d1_q, d1_d;
    logic       rdy_q;
    logic       sysex_d;
    logic       orphan_d;
    logic       accept;

    // Completed message candidate for the output register
    logic       done;
    logic [7:0] o_status;
    logic [6:0] o_d1;
    logic [6:0] o_d2;
    logic [1:0] o_len;

    // Number of data bytes that follow a given status byte
    function automatic logic [1:0] data_len(input logic [7:0] s);
        logic [1:0] n;
        n = 2'd0;
        case (s[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: n = 2'd2;
            4'hC, 4'hD:                   n = 2'd1;
            4'hF: begin
                if (s == 8'hF1 || s == 8'hF3) n = 2'd1;
                else if (s == 8'hF2)          n = 2'd2;
            end
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // Rising edge of rdy means one new byte, whether rdy is a pulse or a level
    assign accept = rx_data_rdy & ~rdy_q;

    // Decode the accepted byte into next parser state and a possible completed message
    always_comb begin
        state_d  = state_q;
        rs_d     = rs_q;
        d1_d     = d1_q;
        sysex_d  = sysex_active;
        orphan_d = 1'b0;
        done     = 1'b0;
        o_status = 8'h00;
        o_d1     = 7'd0;
        o_d2     = 7'd0;
        o_len    = 2'd0;
        if (accept) begin
            if (rx_data >= 8'hF8) begin
                // Real-time: never disturbs parser state
                if (RT_PASS && !(DROP_FE && rx_data == 8'hFE)) begin
                    done     = 1'b1;
                    o_status = rx_data;
                end
            end else if (rx_data[7]) begin
                if (rx_data == 8'hF0) begin
                    rs_d    = 8'h00;
                    sysex_d = 1'b1;
                    state_d = StSysex;
                end else if (rx_data == 8'hF7) begin
                    // End of exclusive outside a frame is ignored
                    if (state_q == StSysex) begin
                        sysex_d = 1'b0;
                        state_d = StIdle;
                    end
                end else if (rx_data == 8'hF4 || rx_data == 8'hF5) begin
                    rs_d    = 8'h00;
                    sysex_d = 1'b0;
                    state_d = StIdle;
                end else if (rx_data == 8'hF6) begin
                    rs_d     = 8'h00;
                    sysex_d  = 1'b0;
                    state_d  = StIdle;
                    done     = 1'b1;
                    o_status = rx_data;
                end else begin
                    // Channel status or F1..F3: wait for data
                    rs_d    = rx_data;
                    sysex_d = 1'b0;
                    state_d = StWaitD1;
                end
            end else begin
                unique case (state_q)
                    StIdle:   orphan_d = 1'b1;
                    StSysex:  ;
                    StWaitD1: begin
                        if (data_len(rs_q) == 2'd2) begin
                            d1_d    = rx_data[6:0];
                            state_d = StWaitD2;
                        end else begin
                            done     = 1'b1;
                            o_status = rs_q;
                            o_d1     = rx_data[6:0];
                            o_len    = 2'd1;
                        end
                    end
                    StWaitD2: begin
                        done     = 1'b1;
                        o_status = rs_q;
                        o_d1     = d1_q;
                        o_d2     = rx_data[6:0];
                        o_len    = 2'd2;
                    end
                endcase
                // Channel messages keep running status; system common drops it
                if (done) begin
                    if (rs_q[7:4] == 4'hF) begin
                        rs_d    = 8'h00;
                        state_d = StIdle;
                    end else begin
                        state_d = StWaitD1;
                    end
                end
            end
        end
    end

    // Parser state and registered outputs, including hold/ack/overflow handling
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            rs_q         <= 8'h00;
            d1_q         <= 7'd0;
            rdy_q        <= 1'b0;
            sysex_active <= 1'b0;
            orphan       <= 1'b0;
            overflow     <= 1'b0;
            msg_valid    <= 1'b0;
            msg_status   <= 8'h00;
            msg_data1    <= 7'd0;
            msg_data2    <= 7'd0;
            msg_len      <= 2'd0;
        end else begin
            state_q      <= state_d;
            rs_q         <= rs_d;
            d1_q         <= d1_d;
            rdy_q        <= rx_data_rdy;
            sysex_active <= sysex_d;
            orphan       <= orphan_d;
            if (done) begin
                if (msg_valid && !msg_ack) begin
                    overflow <= 1'b1;
                end else begin
                    msg_valid  <= 1'b1;
                    msg_status <= o_status;
                    msg_data1  <= o_d1;
                    msg_data2  <= o_d2;
                    msg_len    <= o_len;
                end
            end else if (msg_ack) begin
                msg_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_midi_parser.sv
// Scoreboard bench for midi_parser: three instances (default, RT_PASS=0,
// DROP_FE=1) share one byte stream; each has its own expected-message queue.
module tb_midi_parser;

    typedef struct packed {
        logic [7:0] st;
        logic [6:0] d1;
        logic [6:0] d2;
        logic [1:0] len;
    } msg_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_rdy = 1'b0;
    logic       msg_ack = 1'b1;

    logic [7:0] st[3];
    logic [6:0] d1[3];
    logic [6:0] d2[3];
    logic [1:0] len[3];
    logic       vld[3];
    logic       sx[3];
    logic       ovf[3];
    logic       orph[3];

    int   errors = 0;
    int   checks = 0;
    int   orph_cnt[3] = '{0, 0, 0};
    msg_t q0[$];
    msg_t q1[$];
    msg_t q2[$];

    always #5 clk = ~clk;

    midi_parser u_dut0 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
        .msg_status(st[0]), .msg_data1(d1[0]), .msg_data2(d2[0]), .msg_len(len[0]),
        .msg_valid(vld[0]), .msg_ack(msg_ack), .sysex_active(sx[0]),
        .overflow(ovf[0]), .orphan(orph[0])
    );

    midi_parser #(.RT_PASS(1'b0), .DROP_FE(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
        .msg_status(st[1]), .msg_data1(d1[1]), .msg_data2(d2[1]), .msg_len(len[1]),
        .msg_valid(vld[1]), .msg_ack(msg_ack), .sysex_active(sx[1]),
        .overflow(ovf[1]), .orphan(orph[1])
    );

    midi_parser #(.RT_PASS(1'b1), .DROP_FE(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
        .msg_status(st[2]), .msg_data1(d1[2]), .msg_data2(d2[2]), .msg_len(len[2]),
        .msg_valid(vld[2]), .msg_ack(msg_ack), .sysex_active(sx[2]),
        .overflow(ovf[2]), .orphan(orph[2])
    );

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endfunction

    function automatic msg_t got_msg(input int i);
        return {st[i], d1[i], d2[i], len[i]};
    endfunction

    function automatic logic [27:0] outs(input int i);
        return {st[i], d1[i], d2[i], len[i], vld[i], sx[i], ovf[i], orph[i]};
    endfunction

    function automatic void unexpected(input int i);
        checks++;
        errors++;
        $display("FAIL msg_inst%0d: got unexpected message %h required none", i,
                 32'(got_msg(i)));
    endfunction

    // Monitors: a message is consumed on an edge where valid and ack are both high
    always @(negedge clk) begin
        if (rst && vld[0] && msg_ack) begin
            if (q0.size() == 0) unexpected(0);
            else check("msg_inst0", 32'(got_msg(0)), 32'(q0.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rst && vld[1] && msg_ack) begin
            if (q1.size() == 0) unexpected(1);
            else check("msg_inst1", 32'(got_msg(1)), 32'(q1.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rst && vld[2] && msg_ack) begin
            if (q2.size() == 0) unexpected(2);
            else check("msg_inst2", 32'(got_msg(2)), 32'(q2.pop_front()));
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst && orph[i]) orph_cnt[i]++;
        end
    end

    // mask bit i selects which instance is expected to emit the message
    task automatic expect_msg(input logic [2:0] mask, input logic [7:0] s,
                              input logic [6:0] a, input logic [6:0] b,
                              input logic [1:0] l);
        msg_t m;
        m = {s, a, b, l};
        if (mask[0]) q0.push_back(m);
        if (mask[1]) q1.push_back(m);
        if (mask[2]) q2.push_back(m);
    endtask

    // Called #1 after a rising edge; rdy held for 'hold' cycles then one low cycle
    task automatic send(input logic [7:0] b, input int hold = 1);
        rx_data     = b;
        rx_data_rdy = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        rx_data_rdy = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_orph(input int exp);
        check("orphan_inst0", 32'(orph_cnt[0]), 32'(exp));
        check("orphan_inst1", 32'(orph_cnt[1]), 32'(exp));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_inst0", 32'(outs(0)), 32'h0);
        check("reset_out_inst1", 32'(outs(1)), 32'h0);
        check("reset_out_inst2", 32'(outs(2)), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Note-on, status byte held as a level for several cycles
        expect_msg(3'b111, 8'h90, 7'h3C, 7'h64, 2'd2);
        send(8'h90, 4);
        send(8'h3C);
        send(8'h64);
        check("valid_one_cycle", 32'(vld[0]), 32'h0);
        expect_msg(3'b111, 8'h90, 7'h3E, 7'h00, 2'd2);
        send(8'h3E);
        send(8'h00);

        // Program change with running status
        expect_msg(3'b111, 8'hC5, 7'h07, 7'h00, 2'd1);
        expect_msg(3'b111, 8'hC5, 7'h09, 7'h00, 2'd1);
        send(8'hC5);
        send(8'h07);
        send(8'h09);

        // Real-time interleaved inside a note-on
        expect_msg(3'b101, 8'hF8, 7'h00, 7'h00, 2'd0);
        expect_msg(3'b111, 8'h90, 7'h3C, 7'h64, 2'd2);
        send(8'h90);
        send(8'h3C);
        send(8'hF8);
        send(8'h64);

        // Active sense dropped by DROP_FE and by RT_PASS=0
        expect_msg(3'b001, 8'hFE, 7'h00, 7'h00, 2'd0);
        send(8'hFE);

        // System common: F6 immediate, F2 two bytes, then rs is gone
        expect_msg(3'b111, 8'hF6, 7'h00, 7'h00, 2'd0);
        send(8'hF6);
        expect_msg(3'b111, 8'hF2, 7'h10, 7'h20, 2'd2);
        send(8'hF2);
        send(8'h10);
        send(8'h20);
        send(8'h30);
        check_orph(1);
        expect_msg(3'b111, 8'hF1, 7'h05, 7'h00, 2'd1);
        send(8'hF1);
        send(8'h05);

        // Sysex frame with a real-time byte inside
        send(8'hF0);
        check("sysex_on", 32'(sx[0]), 32'h1);
        send(8'h01);
        send(8'h02);
        expect_msg(3'b101, 8'hF8, 7'h00, 7'h00, 2'd0);
        send(8'hF8);
        check("sysex_rt_inst0", 32'(sx[0]), 32'h1);
        check("sysex_rt_inst1", 32'(sx[1]), 32'h1);
        send(8'hF7);
        check("sysex_off", 32'(sx[0]), 32'h0);
        send(8'h40);
        check_orph(2);

        // Stray F7 does not disturb a pending channel message
        expect_msg(3'b111, 8'h90, 7'h11, 7'h22, 2'd2);
        send(8'h90);
        send(8'hF7);
        send(8'h11);
        send(8'h22);

        // Channel status terminates a sysex frame
        send(8'hF0);
        expect_msg(3'b111, 8'h91, 7'h01, 7'h02, 2'd2);
        send(8'h91);
        check("sysex_ended_by_status", 32'(sx[0]), 32'h0);
        send(8'h01);
        send(8'h02);

        // F4 clears running status
        send(8'hF4);
        send(8'h55);
        check_orph(3);

        // Overflow: second completion dropped while first is held
        msg_ack = 1'b0;
        expect_msg(3'b111, 8'hC3, 7'h01, 7'h00, 2'd1);
        send(8'hC3);
        send(8'h01);
        check("held_valid", 32'(vld[0]), 32'h1);
        check("no_overflow_yet", 32'(ovf[0]), 32'h0);
        send(8'h02);
        check("overflow_set", 32'(ovf[0]), 32'h1);
        check("held_unchanged", 32'(got_msg(0)), {8'h00, 8'hC3, 7'h01, 7'h00, 2'd1});
        // Ack on the same edge as the third completion
        expect_msg(3'b111, 8'hC3, 7'h03, 7'h00, 2'd1);
        rx_data     = 8'h03;
        rx_data_rdy = 1'b1;
        msg_ack     = 1'b1;
        @(posedge clk);
        #1;
        check("valid_stays", 32'(vld[0]), 32'h1);
        check("third_loaded", 32'(got_msg(0)), {8'h00, 8'hC3, 7'h03, 7'h00, 2'd1});
        rx_data_rdy = 1'b0;
        @(posedge clk);
        #1;
        check("overflow_sticky", 32'(ovf[0]), 32'h1);

        // Reset mid-message
        send(8'h90);
        send(8'h3C);
        rst = 1'b0;
        #2;
        check("midreset_out_inst0", 32'(outs(0)), 32'h0);
        check("midreset_out_inst1", 32'(outs(1)), 32'h0);
        check("midreset_out_inst2", 32'(outs(2)), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(8'h64);
        check_orph(4);

        repeat (5) @(posedge clk);
        #1;
        check("queue0_empty", 32'(q0.size()), 32'h0);
        check("queue1_empty", 32'(q1.size()), 32'h0);
        check("queue2_empty", 32'(q2.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
